// File: rtl/latency_data_memory.sv
// Word-addressed memory answering one request at a time after a fixed LATENCY,
// with a single-cycle response pulse and an error flag for misaligned or out-of-range accesses.
module latency_data_memory #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memory_addr,
  input  logic        memory_wren,
  input  logic        memory_rden,
  input  logic [31:0] memory_write_val,
  output logic [31:0] memory_read_val,
  output logic        memory_response,
  output logic        memory_error
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  counter;
  logic [31:0]       cap_addr;
  logic [31:0]       cap_wdata;
  logic              cap_wren;
  logic [31:0]       mem [DEPTH];

  logic                  accept_c;
  logic                  fire_c;
  logic                  access_err_c;
  logic [DEPTH_LOG2-1:0] index_c;

  assign accept_c     = (state == IDLE) && (memory_wren || memory_rden);
  assign fire_c       = (state == WAIT) && (counter == '0);
  assign index_c      = cap_addr[DEPTH_LOG2+1:2];
  assign access_err_c = (cap_addr[1:0] != 2'b00) || (cap_addr[31:DEPTH_LOG2+2] != '0);

  // Next-state logic; the counter gates the single exit from WAIT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c) state_next = WAIT;
      WAIT:    if (fire_c) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      counter         <= '0;
      cap_addr        <= '0;
      cap_wdata       <= '0;
      cap_wren        <= 1'b0;
      memory_response <= 1'b0;
      memory_read_val <= '0;
      memory_error    <= 1'b0;
    end else begin
      state           <= state_next;
      memory_response <= fire_c;
      if (accept_c) begin
        cap_addr        <= memory_addr;
        cap_wdata       <= memory_write_val;
        cap_wren        <= memory_wren;
        counter         <= CNT_W'(LATENCY - 1);
        memory_read_val <= '0;
        memory_error    <= 1'b0;
      end else if ((state == WAIT) && (counter != '0)) begin
        counter <= counter - CNT_W'(1);
      end
      if (fire_c) begin
        memory_error <= access_err_c;
        if (access_err_c) begin
          memory_read_val <= '0;
        end else if (cap_wren) begin
          memory_read_val <= cap_wdata;
        end else begin
          memory_read_val <= mem[index_c];
        end
      end
    end
  end

  // Storage is deliberately left unreset; an aborted access never reaches fire_c.
  always_ff @(posedge clk) begin
    if (fire_c && cap_wren && !access_err_c) begin
      mem[index_c] <= cap_wdata;
    end
  end

endmodule
